// File: rtl/can_fault_controller.sv
// can_fault_controller: sequences the CAN error frame (flag, wait for recessive,
// delimiter) and maintains the TEC/REC fault-confinement counters and node state.
// All progress is paced by the bit sample-point strobe SP.
module can_fault_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       SP,
  input  logic       RX,
  input  logic       ERROR,
  input  logic       TX_MODE,
  input  logic       FRAME_OK,
  output logic       TX_ERR,
  output logic       ERR_FRAME,
  output logic       DEC_RESET,
  output logic [8:0] TEC,
  output logic [7:0] REC,
  output logic [1:0] ERR_STATE
);

  typedef enum logic [2:0] {
    IDLE,
    FLAG,
    WAIT_REC,
    DELIM,
    BUS_OFF
  } state_t;

  state_t     state, state_next;
  logic [2:0] flag_cnt, flag_cnt_next;
  logic [3:0] delim_cnt, delim_cnt_next;
  logic [2:0] dom_cnt, dom_cnt_next;
  logic       first_strobe, first_strobe_next;
  logic [3:0] run_cnt, run_cnt_next;
  logic [6:0] recov_cnt, recov_cnt_next;
  logic       tx_err_next, err_frame_next, dec_reset_next;
  logic [8:0] tec_sum;
  logic [8:0] rec_sum;
  logic [8:0] tec_next;
  logic [7:0] rec_next;
  logic       start_flag;
  logic       passive;

  // Node state is derived straight from the registered counters; TEC >= 256 is bus-off.
  assign passive   = TEC[8] | TEC[7] | REC[7];
  assign ERR_STATE = TEC[8] ? 2'b10 : {1'b0, passive};

  // Next-state, counter arithmetic and next output values; nothing moves without SP.
  always_comb begin
    state_next        = state;
    flag_cnt_next     = flag_cnt;
    delim_cnt_next    = delim_cnt;
    dom_cnt_next      = dom_cnt;
    first_strobe_next = first_strobe;
    run_cnt_next      = run_cnt;
    recov_cnt_next    = recov_cnt;
    tx_err_next       = TX_ERR;
    err_frame_next    = ERR_FRAME;
    dec_reset_next    = 1'b0;
    tec_sum           = TEC;
    rec_sum           = {1'b0, REC};
    start_flag        = 1'b0;

    if (SP) begin
      unique case (state)
        IDLE: begin
          if (ERROR) begin
            start_flag = 1'b1;
          end else if (FRAME_OK) begin
            if (TX_MODE) begin
              if (TEC != 9'd0) tec_sum = TEC - 9'd1;
            end else if (REC > 8'd127) begin
              rec_sum = 9'd119;
            end else if (REC != 8'd0) begin
              rec_sum = {1'b0, REC} - 9'd1;
            end
          end
        end
        FLAG: begin
          if (flag_cnt == 3'd5) begin
            state_next        = WAIT_REC;
            tx_err_next       = 1'b1;
            first_strobe_next = 1'b1;
            dom_cnt_next      = 3'd0;
          end else begin
            flag_cnt_next = flag_cnt + 3'd1;
          end
        end
        WAIT_REC: begin
          first_strobe_next = 1'b0;
          if (RX) begin
            state_next     = DELIM;
            delim_cnt_next = 4'd1;
            dom_cnt_next   = 3'd0;
          end else begin
            if (first_strobe && !TX_MODE) rec_sum = rec_sum + 9'd8;
            if (dom_cnt == 3'd7) begin
              dom_cnt_next = 3'd0;
              if (TX_MODE) tec_sum = tec_sum + 9'd8;
              else         rec_sum = rec_sum + 9'd8;
            end else begin
              dom_cnt_next = dom_cnt + 3'd1;
            end
          end
        end
        DELIM: begin
          if (RX) begin
            if (delim_cnt == 4'd7) begin
              state_next     = IDLE;
              err_frame_next = 1'b0;
              dec_reset_next = 1'b1;
              delim_cnt_next = 4'd0;
            end else begin
              delim_cnt_next = delim_cnt + 4'd1;
            end
          end else begin
            start_flag = 1'b1;
          end
        end
        BUS_OFF: begin
          if (RX) begin
            if (run_cnt == 4'd10) begin
              run_cnt_next = 4'd0;
              if (recov_cnt == 7'd127) begin
                recov_cnt_next = 7'd0;
                state_next     = IDLE;
                tec_sum        = 9'd0;
                rec_sum        = 9'd0;
                dec_reset_next = 1'b1;
              end else begin
                recov_cnt_next = recov_cnt + 7'd1;
              end
            end else begin
              run_cnt_next = run_cnt + 4'd1;
            end
          end else begin
            run_cnt_next = 4'd0;
          end
        end
        default: state_next = IDLE;
      endcase

      // A new error frame: flag polarity is fixed by the node state before this error counts.
      if (start_flag) begin
        state_next     = FLAG;
        flag_cnt_next  = 3'd0;
        err_frame_next = 1'b1;
        tx_err_next    = passive;
        if (TX_MODE) tec_sum = tec_sum + 9'd8;
        else         rec_sum = rec_sum + 9'd1;
      end

      // Reaching TEC 256 anywhere outside bus-off abandons whatever frame is running.
      if (state != BUS_OFF && tec_sum[8]) begin
        state_next     = BUS_OFF;
        tx_err_next    = 1'b1;
        err_frame_next = 1'b0;
        dec_reset_next = 1'b0;
        run_cnt_next   = 4'd0;
        recov_cnt_next = 7'd0;
      end
    end

    tec_next = tec_sum;
    rec_next = rec_sum[8] ? 8'hFF : rec_sum[7:0];
  end

  // State, counters and all outputs are registered together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      flag_cnt     <= 3'd0;
      delim_cnt    <= 4'd0;
      dom_cnt      <= 3'd0;
      first_strobe <= 1'b0;
      run_cnt      <= 4'd0;
      recov_cnt    <= 7'd0;
      TX_ERR       <= 1'b1;
      ERR_FRAME    <= 1'b0;
      DEC_RESET    <= 1'b0;
      TEC          <= 9'd0;
      REC          <= 8'd0;
    end else begin
      state        <= state_next;
      flag_cnt     <= flag_cnt_next;
      delim_cnt    <= delim_cnt_next;
      dom_cnt      <= dom_cnt_next;
      first_strobe <= first_strobe_next;
      run_cnt      <= run_cnt_next;
      recov_cnt    <= recov_cnt_next;
      TX_ERR       <= tx_err_next;
      ERR_FRAME    <= err_frame_next;
      DEC_RESET    <= dec_reset_next;
      TEC          <= tec_next;
      REC          <= rec_next;
    end
  end

endmodule

// File: tb/tb_can_fault_controller.sv
// tb_can_fault_controller: directed error-frame scenarios for can_fault_controller,
// with expected snapshots and DEC_RESET pulse positions held in scoreboard queues.
module tb_can_fault_controller;

  logic       clock;
  logic       reset;
  logic       SP, RX, ERROR, TX_MODE, FRAME_OK;
  logic       TX_ERR, ERR_FRAME, DEC_RESET;
  logic [8:0] TEC;
  logic [7:0] REC;
  logic [1:0] ERR_STATE;

  typedef struct {
    string      name;
    logic       tx_err;
    logic       err_frame;
    int         tec;
    int         rec;
    logic [1:0] es;
  } exp_t;

  exp_t exp_q[$];
  int   dec_q[$];
  int   sp_count = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t mon_e;
  int   mon_idx;
  logic es_ok;

  can_fault_controller dut (
    .clock    (clock),
    .reset    (reset),
    .SP       (SP),
    .RX       (RX),
    .ERROR    (ERROR),
    .TX_MODE  (TX_MODE),
    .FRAME_OK (FRAME_OK),
    .TX_ERR   (TX_ERR),
    .ERR_FRAME(ERR_FRAME),
    .DEC_RESET(DEC_RESET),
    .TEC      (TEC),
    .REC      (REC),
    .ERR_STATE(ERR_STATE)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: just after each falling edge, drain pending snapshots and match DEC_RESET pulses.
  always begin
    @(negedge clock);
    #1;
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      es_ok = mon_e.es[1] ? (ERR_STATE[1] === 1'b1) : (ERR_STATE === mon_e.es);
      if (TX_ERR !== mon_e.tx_err || ERR_FRAME !== mon_e.err_frame ||
          TEC !== mon_e.tec[8:0] || REC !== mon_e.rec[7:0] || !es_ok) begin
        errors++;
        $display("[TB] FAIL %s: got tx=%b frame=%b tec=%0d rec=%0d state=%b, expected tx=%b frame=%b tec=%0d rec=%0d state=%b",
                 mon_e.name, TX_ERR, ERR_FRAME, TEC, REC, ERR_STATE,
                 mon_e.tx_err, mon_e.err_frame, mon_e.tec, mon_e.rec, mon_e.es);
      end
    end
    if (DEC_RESET === 1'b1) begin
      checks++;
      if (dec_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL dec_reset_unexpected: got pulse at strobe %0d, expected none", sp_count);
      end else begin
        mon_idx = dec_q.pop_front();
        if (mon_idx != sp_count) begin
          errors++;
          $display("[TB] FAIL dec_reset_timing: got pulse at strobe %0d, expected strobe %0d", sp_count, mon_idx);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rx, input logic err, input logic txm, input logic fok);
    @(negedge clock);
    RX       = rx;
    ERROR    = err;
    TX_MODE  = txm;
    FRAME_OK = fok;
    SP       = 1'b1;
    sp_count++;
    @(negedge clock);
    SP       = 1'b0;
    ERROR    = 1'b0;
    FRAME_OK = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic tx, input logic ef,
                             input int tec, input int rec, input logic [1:0] es);
    exp_t e;
    e.name      = name;
    e.tx_err    = tx;
    e.err_frame = ef;
    e.tec       = tec;
    e.rec       = rec;
    e.es        = es;
    exp_q.push_back(e);
  endtask

  // One complete error frame: error strobe, 6 flag bits, optional dominant first
  // wait bit, then 8 recessive delimiter bits ending in a DEC_RESET pulse.
  task automatic do_error(input string name, input logic txm, input logic fok,
                          input logic dom_first, input logic flag_lvl,
                          input int e_tec, input int e_rec, input logic [1:0] e_es,
                          input int f_rec, input logic [1:0] f_es);
    int last;
    last = sp_count + 15 + (dom_first ? 1 : 0);
    dec_q.push_back(last);
    applyStimulus(1'b1, 1'b1, txm, fok);
    checkOutput({name, "_entry"}, flag_lvl, 1'b1, e_tec, e_rec, e_es);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 1'b0, txm, 1'b0);
      if (i < 6) checkOutput({name, "_flag"}, flag_lvl, 1'b1, e_tec, e_rec, e_es);
      else       checkOutput({name, "_flag_end"}, 1'b1, 1'b1, e_tec, e_rec, e_es);
    end
    if (dom_first) begin
      applyStimulus(1'b0, 1'b0, txm, 1'b0);
      checkOutput({name, "_wait_dom"}, 1'b1, 1'b1, e_tec, f_rec, f_es);
    end
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, txm, 1'b0);
      if (i < 8) checkOutput({name, "_delim"}, 1'b1, 1'b1, e_tec, f_rec, f_es);
      else       checkOutput({name, "_done"}, 1'b1, 1'b0, e_tec, f_rec, f_es);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    reset    = 1'b0;
    SP       = 1'b0;
    RX       = 1'b1;
    ERROR    = 1'b0;
    TX_MODE  = 1'b0;
    FRAME_OK = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_state", 1'b1, 1'b0, 0, 0, 2'b00);
    @(negedge clock);
    reset = 1'b1;

    // Receiver error on a clean bus.
    do_error("rx_clean", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 2'b00, 1, 2'b00);

    // Error and FRAME_OK together: error wins, no decrement.
    do_error("collision", 1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 2'b00, 2, 2'b00);

    // Receiver FRAME_OK decrements down to the floor of 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rec_dec_1", 1'b1, 1'b0, 0, 1, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rec_dec_0", 1'b1, 1'b0, 0, 0, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rec_floor", 1'b1, 1'b0, 0, 0, 2'b00);

    // Transmitter error, then FRAME_OK as transmitter.
    do_error("tx_first", 1'b1, 1'b0, 1'b0, 1'b0, 8, 0, 2'b00, 0, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("tec_dec", 1'b1, 1'b0, 7, 0, 2'b00);

    // Reset asserted in the middle of a flag.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pre_reset_entry", 1'b0, 1'b1, 15, 0, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset_flag", 1'b0, 1'b1, 15, 0, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_mid_flag", 1'b1, 1'b0, 0, 0, 2'b00);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Transmitter errors up to passive (16th) and a passive flag (17th), on toward bus-off.
    for (int i = 1; i <= 31; i++) begin
      do_error("tx_climb", 1'b1, 1'b0, 1'b0, (i >= 17) ? 1'b1 : 1'b0,
               8 * i, 0, (8 * i >= 128) ? 2'b01 : 2'b00,
               0, (8 * i >= 128) ? 2'b01 : 2'b00);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bus_off_entry", 1'b1, 1'b0, 256, 0, 2'b10);

    // Plain recovery: 128 runs of 11 recessive bits; ERROR/FRAME_OK ignored.
    dec_q.push_back(sp_count + 1408);
    for (int n = 1; n <= 1408; n++) begin
      applyStimulus(1'b1, n == 1, 1'b1, n == 1);
      if (n == 1407) checkOutput("bus_off_hold", 1'b1, 1'b0, 256, 0, 2'b10);
      if (n == 1408) checkOutput("recovered", 1'b1, 1'b0, 0, 0, 2'b00);
    end

    // Bus-off reached by a long dominant run in WAIT_REC aborts the error frame.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("abort_entry", 1'b0, 1'b1, 8, 0, 2'b00);
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_wait", 1'b1, 1'b1, 8, 0, 2'b00);
    for (int n = 1; n <= 248; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      if (n == 247) checkOutput("dom_run", 1'b1, 1'b1, 248, 0, 2'b01);
      if (n == 248) checkOutput("abort_bus_off", 1'b1, 1'b0, 256, 0, 2'b10);
    end

    // Recovery with a dominant bit at run position 10: 10 extra strobes.
    dec_q.push_back(sp_count + 1418);
    for (int n = 1; n <= 1418; n++) begin
      applyStimulus((n == 10) ? 1'b0 : 1'b1, 1'b0, 1'b1, 1'b0);
      if (n == 1417) checkOutput("delayed_hold", 1'b1, 1'b0, 256, 0, 2'b10);
      if (n == 1418) checkOutput("delayed_recovered", 1'b1, 1'b0, 0, 0, 2'b00);
    end

    // Preload REC to 130: 14 errors at +9, then 4 clean receiver errors.
    for (int j = 1; j <= 14; j++) begin
      do_error("rec_load", 1'b0, 1'b0, 1'b1, 1'b0, 0, 9 * j - 8, 2'b00, 9 * j, 2'b00);
    end
    for (int j = 1; j <= 4; j++) begin
      do_error("rec_edge", 1'b0, 1'b0, 1'b0, (j >= 3) ? 1'b1 : 1'b0,
               0, 126 + j, (126 + j >= 128) ? 2'b01 : 2'b00,
               126 + j, (126 + j >= 128) ? 2'b01 : 2'b00);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rec_to_119", 1'b1, 1'b0, 0, 119, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rec_118", 1'b1, 1'b0, 0, 118, 2'b00);

    // Dominant at delimiter bit 4 starts a new flag on that strobe.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("delim_entry", 1'b0, 1'b1, 0, 119, 2'b00);
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("delim_bit3", 1'b1, 1'b1, 0, 119, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("delim_reflag", 1'b0, 1'b1, 0, 120, 2'b00);
    dec_q.push_back(sp_count + 14);
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reflag_end", 1'b1, 1'b1, 0, 120, 2'b00);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reflag_done", 1'b1, 1'b0, 0, 120, 2'b00);

    repeat (4) @(negedge clock);
    while (dec_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL dec_reset_missing: got no pulse, expected strobe %0d", dec_q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
